// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores over valid/ready handshakes,
// with misaligned accesses split into two word transactions on a byte-enable RAM.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 7,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [31:0] InitWord = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StDone,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Request decode, evaluated on the live request fields at acceptance.
  logic [1:0]        off_in;
  logic [ADDR_W-1:0] w0_in;
  logic              cross_in;
  logic              err_in;
  logic              accept;

  assign off_in = req_addr[1:0];
  assign w0_in  = req_addr[ADDR_W+1:2];

  always_comb begin
    cross_in = ((req_size == SizeWord) && (off_in != 2'd0)) ||
               ((req_size == SizeHalf) && (off_in == 2'd3));
    err_in   = (req_size == 2'b11) ||
               ((req_addr >> (ADDR_W + 2)) != 32'd0) ||
               (cross_in && (w0_in == {ADDR_W{1'b1}}));
  end

  assign req_ready  = (state_q == StIdle) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == StResp);

  // Latched request.
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] w0_q;
  logic              cross_q;
  logic [31:0]       wdata_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      sign_q  <= req_sign;
      off_q   <= off_in;
      w0_q    <= w0_in;
      cross_q <= cross_in;
      wdata_q <= req_wdata;
    end
  end

  // Store data and byte enables as a 64-bit two-word window starting at w0.
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;

  always_comb begin
    size_mask = 4'b0001;
    case (size_q)
      SizeWord: size_mask = 4'b1111;
      SizeHalf: size_mask = 4'b0011;
      SizeByte: size_mask = 4'b0001;
      default:  size_mask = 4'b0001;
    endcase
    lane_mask = {4'b0000, size_mask} << off_q;
    lane_data = {32'h0, wdata_q} << {off_q, 3'b000};
  end

  // RAM port control.
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_wr;
  logic              ram_re;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always_comb begin
    ram_addr  = w0_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'b0000;
    ram_wdata = lane_data[31:0];
    case (state_q)
      StAcc0: begin
        ram_we = we_q;
        ram_re = !we_q;
        ram_be = lane_mask[3:0];
      end
      StAcc1: begin
        ram_addr  = w0_q + ADDR_W'(1);
        ram_we    = we_q;
        ram_re    = !we_q;
        ram_be    = lane_mask[7:4];
        ram_wdata = lane_data[63:32];
      end
      default: begin
      end
    endcase
  end

  // Reset on the same edge suppresses the write, so an aborted split store keeps only its
  // first half.
  assign ram_wr = ram_we && !rst;

  logic [31:0] mem [Depth] = '{default: InitWord};

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  // Holds the first word of a split load while the second word is read.
  logic [31:0] rbuf_q;

  always_ff @(posedge clk) begin
    if ((state_q == StAcc1) && !we_q) begin
      rbuf_q <= ram_rdata;
    end
  end

  // Load assembly: align the addressed bytes to bit 0 then extend.
  logic [63:0] combined;
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    combined = cross_q ? {ram_rdata, rbuf_q} : {32'h0, ram_rdata};
    shifted  = 32'(combined >> {off_q, 3'b000});
    load_val = shifted;
    case (size_q)
      SizeWord: load_val = shifted;
      SizeHalf: load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default:  load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
    endcase
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = err_in ? StResp : StAcc0;
        end
      end
      StAcc0: state_d = cross_q ? StAcc1 : StDone;
      StAcc1: state_d = StDone;
      StDone: state_d = StResp;
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && err_in) begin
        resp_rdata_q <= 32'h0;
        resp_err_q   <= 1'b1;
      end
      if (state_q == StDone) begin
        resp_rdata_q <= we_q ? 32'h0 : load_val;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
